ufm_arbiter: RTL and testbench

UFM_ARBITER -- requirements
Module: ufm_arbiter

---
 rtl/ufm_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ufm_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ufm_arbiter.sv
// Arbitrates CPU instruction fetches and data reads onto the serial UFM
// port, with a one-entry fetch cache in front of the fetch path.
module ufm_arbiter #(
    parameter int unsigned DIV = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [8:0]  if_addr,
    output logic [15:0] if_data,
    output logic        if_ready,
    input  logic        dt_req,
    input  logic [8:0]  dt_addr,
    output logic [15:0] dt_data,
    output logic        dt_ack,
    output logic        ufm_arclk,
    output logic        ufm_ardin,
    output logic        ufm_arshft,
    output logic        ufm_drclk,
    output logic        ufm_drshft,
    input  logic        ufm_drdout,
    input  logic        ufm_busy
);

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);

    typedef enum logic [2:0] {IDLE, ADDR, LOAD, SHIFT, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] div_cnt, div_nx;
    logic [CW-1:0] bit_cnt, bit_nx;
    logic          hi, hi_nx;
    logic [AW-1:0] sr, sr_nx;
    logic          sel_data, sel_nx;
    logic          last_data, last_nx;
    logic [DW-1:0] result, result_nx;
    logic [AW-1:0] tag;
    logic [DW-1:0] word;
    logic          valid;
    logic          arclk_nx, ardin_nx, arshft_nx, drclk_nx, drshft_nx, dt_ack_nx;
    logic          phase_end, bit_end, fetch_pend, grant_data;

    // Cache hit is combinational so a cached pc is served in the same cycle
    assign if_ready   = valid && (tag == if_addr);
    assign if_data    = word;
    assign phase_end  = (div_cnt == DIV_LAST);
    assign bit_end    = phase_end && hi;
    assign fetch_pend = !if_ready;
    // Data wins unless fetch is also pending and data was granted last
    assign grant_data = dt_req && (!fetch_pend || !last_data);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus phase/bit counters; address register rotates so it is whole again at DONE
    always_comb begin
        state_nx  = state;
        div_nx    = div_cnt;
        hi_nx     = hi;
        bit_nx    = bit_cnt;
        sr_nx     = sr;
        sel_nx    = sel_data;
        last_nx   = last_data;
        result_nx = result;
        if (state inside {ADDR, LOAD, SHIFT}) begin
            if (phase_end) begin
                div_nx = '0;
                hi_nx  = !hi;
            end else begin
                div_nx = div_cnt + CW'(1);
            end
        end
        case (state)
            IDLE: begin
                if (!ufm_busy && (fetch_pend || dt_req)) begin
                    state_nx = ADDR;
                    sel_nx   = grant_data;
                    last_nx  = grant_data;
                    sr_nx    = grant_data ? dt_addr : if_addr;
                    div_nx   = '0;
                    hi_nx    = 1'b0;
                    bit_nx   = '0;
                end
            end
            ADDR: begin
                if (bit_end) begin
                    sr_nx = {sr[AW-2:0], sr[AW-1]};
                    if (bit_cnt == ADDR_LAST) begin
                        state_nx = LOAD;
                        bit_nx   = '0;
                    end else begin
                        bit_nx = bit_cnt + CW'(1);
                    end
                end
            end
            LOAD: begin
                if (bit_end) begin
                    state_nx = SHIFT;
                    bit_nx   = '0;
                end
            end
            SHIFT: begin
                if (phase_end && !hi) begin
                    result_nx = {result[DW-2:0], ufm_drdout};
                end
                if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        state_nx = DONE;
                        bit_nx   = '0;
                    end else begin
                        bit_nx = bit_cnt + CW'(1);
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Pin values for the coming cycle, decoded from next state so pins stay aligned with state
    always_comb begin
        arshft_nx = (state_nx == ADDR);
        arclk_nx  = arshft_nx && hi_nx;
        ardin_nx  = arshft_nx && sr_nx[AW-1];
        drshft_nx = (state_nx != LOAD);
        drclk_nx  = ((state_nx == LOAD) || (state_nx == SHIFT)) && hi_nx;
        dt_ack_nx = (state_nx == DONE) && sel_nx;
    end

    // Datapath, cache and registered pins
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            hi         <= 1'b0;
            sr         <= '0;
            sel_data   <= 1'b0;
            last_data  <= 1'b0;
            result     <= '0;
            tag        <= '0;
            word       <= '0;
            valid      <= 1'b0;
            dt_data    <= '0;
            dt_ack     <= 1'b0;
            ufm_arclk  <= 1'b0;
            ufm_ardin  <= 1'b0;
            ufm_arshft <= 1'b0;
            ufm_drclk  <= 1'b0;
            ufm_drshft <= 1'b1;
        end else begin
            div_cnt    <= div_nx;
            bit_cnt    <= bit_nx;
            hi         <= hi_nx;
            sr         <= sr_nx;
            sel_data   <= sel_nx;
            last_data  <= last_nx;
            result     <= result_nx;
            dt_ack     <= dt_ack_nx;
            ufm_arclk  <= arclk_nx;
            ufm_ardin  <= ardin_nx;
            ufm_arshft <= arshft_nx;
            ufm_drclk  <= drclk_nx;
            ufm_drshft <= drshft_nx;
            if ((state == SHIFT) && (state_nx == DONE)) begin
                if (sel_data) begin
                    dt_data <= result;
                end else begin
                    tag   <= sr;
                    word  <= result;
                    valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ufm_arbiter.sv
// Bench for ufm_arbiter: DIV=1 and DIV=3 instances, a behavioural UFM
// device, a timeline model of the expected pins, and directed scenarios.
module tb_ufm_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [8:0]  if_addr [2];
    logic [15:0] if_data [2];
    logic        if_ready[2];
    logic        dt_req  [2];
    logic [8:0]  dt_addr [2];
    logic [15:0] dt_data [2];
    logic        dt_ack  [2];
    logic        arclk[2], ardin[2], arshft[2], drclk[2], drshft[2], drdout[2], busy[2];

    logic [15:0] mem [512];
    logic [8:0]  areg[2];
    logic [15:0] dreg[2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    ufm_arbiter #(.DIV(1)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .if_addr(if_addr[0]), .if_data(if_data[0]), .if_ready(if_ready[0]),
        .dt_req(dt_req[0]), .dt_addr(dt_addr[0]), .dt_data(dt_data[0]), .dt_ack(dt_ack[0]),
        .ufm_arclk(arclk[0]), .ufm_ardin(ardin[0]), .ufm_arshft(arshft[0]),
        .ufm_drclk(drclk[0]), .ufm_drshft(drshft[0]), .ufm_drdout(drdout[0]),
        .ufm_busy(busy[0])
    );

    ufm_arbiter #(.DIV(3)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .if_addr(if_addr[1]), .if_data(if_data[1]), .if_ready(if_ready[1]),
        .dt_req(dt_req[1]), .dt_addr(dt_addr[1]), .dt_data(dt_data[1]), .dt_ack(dt_ack[1]),
        .ufm_arclk(arclk[1]), .ufm_ardin(ardin[1]), .ufm_arshft(arshft[1]),
        .ufm_drclk(drclk[1]), .ufm_drshft(drshft[1]), .ufm_drdout(drdout[1]),
        .ufm_busy(busy[1])
    );

    assign drdout[0] = dreg[0][15];
    assign drdout[1] = dreg[1][15];

    // UFM device behaviour plus pin-activity counters for dut1/dut3
    logic       prev_ar[2], prev_dr[2];
    logic [4:0] prev_pins0;
    logic [8:0] ardin_seq0;
    int ar_rise0 = 0, dr_rise0 = 0, dr_rise1 = 0, pin_tog0 = 0, ack_cnt0 = 0;
    always @(negedge clock) begin
        for (int g = 0; g < 2; g++) begin
            if (arclk[g] && !prev_ar[g] && arshft[g])
                areg[g] <= {areg[g][7:0], ardin[g]};
            if (drclk[g] && !prev_dr[g])
                dreg[g] <= drshft[g] ? {dreg[g][14:0], 1'b0} : mem[areg[g]];
            prev_ar[g] <= arclk[g];
            prev_dr[g] <= drclk[g];
        end
        if (arclk[0] && !prev_ar[0]) begin
            ar_rise0   <= ar_rise0 + 1;
            ardin_seq0 <= {ardin_seq0[7:0], ardin[0]};
        end
        if (drclk[0] && !prev_dr[0]) dr_rise0 <= dr_rise0 + 1;
        if (drclk[1] && !prev_dr[1]) dr_rise1 <= dr_rise1 + 1;
        if ({arclk[0], ardin[0], arshft[0], drclk[0], drshft[0]} != prev_pins0)
            pin_tog0 <= pin_tog0 + 1;
        prev_pins0 <= {arclk[0], ardin[0], arshft[0], drclk[0], drshft[0]};
        if (dt_ack[0]) ack_cnt0 <= ack_cnt0 + 1;
    end

    // Transaction model: k counts cycles since the grant edge; DONE is k == 52*DIV
    logic       m_act[2], m_sel[2], m_last[2], m_valid[2];
    int         m_k[2];
    logic [8:0] m_addr[2], m_tag[2];
    logic [15:0] m_word[2], m_dtd[2];
    always @(posedge clock or negedge reset_n) begin
        for (int g = 0; g < 2; g++) begin
            int   d;
            logic fp, dp, sel;
            d = (g == 0) ? 1 : 3;
            if (!reset_n) begin
                m_act[g]   <= 1'b0;
                m_sel[g]   <= 1'b0;
                m_last[g]  <= 1'b0;
                m_valid[g] <= 1'b0;
                m_tag[g]   <= '0;
                m_dtd[g]   <= '0;
                m_k[g]     <= 0;
            end else if (!m_act[g]) begin
                fp = !(m_valid[g] && (m_tag[g] == if_addr[g]));
                dp = dt_req[g];
                if (!busy[g] && (fp || dp)) begin
                    sel = dp && (!fp || !m_last[g]);
                    m_sel[g]  <= sel;
                    m_last[g] <= sel;
                    m_addr[g] <= sel ? dt_addr[g] : if_addr[g];
                    m_act[g]  <= 1'b1;
                    m_k[g]    <= 0;
                end
            end else if (m_k[g] >= 52 * d) begin
                m_act[g] <= 1'b0;
            end else begin
                m_k[g] <= m_k[g] + 1;
                if (m_k[g] + 1 == 52 * d) begin
                    if (m_sel[g]) begin
                        m_dtd[g] <= mem[m_addr[g]];
                    end else begin
                        m_valid[g] <= 1'b1;
                        m_tag[g]   <= m_addr[g];
                        m_word[g]  <= mem[m_addr[g]];
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int g, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, g, $time, got, exp);
        end
    endtask

    // Compare every output of both instances against the model timeline
    task automatic compare_all();
        for (int g = 0; g < 2; g++) begin
            int   d, k, bi;
            logic a, l, s, e_arclk, e_ardin, e_drclk, e_ack, e_ready;
            d = (g == 0) ? 1 : 3;
            k = m_k[g];
            a = m_act[g] && (k < 18 * d);
            l = m_act[g] && (k >= 18 * d) && (k < 20 * d);
            s = m_act[g] && (k >= 20 * d) && (k < 52 * d);
            e_arclk = 1'b0;
            e_ardin = 1'b0;
            e_drclk = 1'b0;
            if (a) begin
                bi      = k / (2 * d);
                e_arclk = (k % (2 * d)) >= d;
                e_ardin = m_addr[g][8 - bi];
            end
            if (l) e_drclk = (k - 18 * d) >= d;
            if (s) e_drclk = ((k - 20 * d) % (2 * d)) >= d;
            e_ack   = m_act[g] && (k == 52 * d) && m_sel[g];
            e_ready = m_valid[g] && (m_tag[g] == if_addr[g]);
            chk("arshft", g, 16'(arshft[g]), 16'(a));
            chk("arclk", g, 16'(arclk[g]), 16'(e_arclk));
            chk("ardin", g, 16'(ardin[g]), 16'(e_ardin));
            chk("drshft", g, 16'(drshft[g]), 16'(!l));
            chk("drclk", g, 16'(drclk[g]), 16'(e_drclk));
            chk("dt_ack", g, 16'(dt_ack[g]), 16'(e_ack));
            chk("dt_data", g, dt_data[g], m_dtd[g]);
            chk("if_ready", g, 16'(if_ready[g]), 16'(e_ready));
            if (m_valid[g]) chk("if_data", g, if_data[g], m_word[g]);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            compare_all();
            #1;
        end
    endtask

    task automatic chk_idle_pins(input int g);
        chk("rst_arclk", g, 16'(arclk[g]), 16'h0);
        chk("rst_ardin", g, 16'(ardin[g]), 16'h0);
        chk("rst_arshft", g, 16'(arshft[g]), 16'h0);
        chk("rst_drclk", g, 16'(drclk[g]), 16'h0);
        chk("rst_drshft", g, 16'(drshft[g]), 16'h1);
        chk("rst_dt_ack", g, 16'(dt_ack[g]), 16'h0);
        chk("rst_if_ready", g, 16'(if_ready[g]), 16'h0);
    endtask

    int snap_ar, snap_dr, snap_tog, snap_ack;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'(i * 40503) ^ 16'h5A5A;
        mem[0]     = 16'h1234;
        mem[5]     = 16'hA55A;
        mem[9'h1FF] = 16'hBEEF;
        reset_n = 1'b1;
        for (int g = 0; g < 2; g++) begin
            dt_req[g]  = 1'b0;
            dt_addr[g] = '0;
            busy[g]    = 1'b0;
        end
        if_addr[0] = 9'h000;
        if_addr[1] = 9'h0AA;
        #1 reset_n = 1'b0;

        // Reset values, then first fetch of word 0 on both instances
        tick(2);
        chk_idle_pins(0);
        chk_idle_pins(1);
        chk("rst_dt_data", 0, dt_data[0], 16'h0000);
        reset_n = 1'b1;
        tick(52);
        chk("fetch0_not_ready", 0, 16'(if_ready[0]), 16'h0);
        tick(1);
        chk("fetch0_ready", 0, 16'(if_ready[0]), 16'h1);
        chk("fetch0_data", 0, if_data[0], 16'h1234);

        // Fetch 0x005: address bits, drclk pulse count, cached word
        tick(1);
        snap_ar = ar_rise0;
        snap_dr = dr_rise0;
        if_addr[0] = 9'h005;
        tick(52);
        chk("fetch5_not_ready", 0, 16'(if_ready[0]), 16'h0);
        tick(1);
        chk("fetch5_ready", 0, 16'(if_ready[0]), 16'h1);
        chk("fetch5_data", 0, if_data[0], 16'hA55A);
        chk("fetch5_ardin_seq", 0, 16'(ardin_seq0), 16'h0005);
        chk("fetch5_arclk_pulses", 0, 16'(ar_rise0 - snap_ar), 16'd9);
        chk("fetch5_drclk_pulses", 0, 16'(dr_rise0 - snap_dr), 16'd17);
        tick(1);
        if_addr[0] = 9'h000;
        #1 chk("miss_comb", 0, 16'(if_ready[0]), 16'h0);
        if_addr[0] = 9'h005;
        #1 chk("hit_comb", 0, 16'(if_ready[0]), 16'h1);
        snap_ar = ar_rise0;
        tick(10);
        chk("hit_no_arclk", 0, 16'(ar_rise0 - snap_ar), 16'd0);

        // DIV=3 fetch of 0x0AA completes 157 cycles after release
        tick(38);
        chk("div3_not_ready", 1, 16'(if_ready[1]), 16'h0);
        tick(1);
        chk("div3_ready", 1, 16'(if_ready[1]), 16'h1);
        chk("div3_data", 1, if_data[1], mem[9'h0AA]);
        chk("div3_drclk_pulses", 1, 16'(dr_rise1), 16'd17);

        // Simultaneous fetch and data after reset: data first, then fetch
        reset_n    = 1'b0;
        if_addr[0] = 9'h010;
        dt_req[0]  = 1'b1;
        dt_addr[0] = 9'h1FF;
        tick(2);
        reset_n = 1'b1;
        tick(52);
        chk("rr_ack_early", 0, 16'(dt_ack[0]), 16'h0);
        tick(1);
        chk("rr_ack", 0, 16'(dt_ack[0]), 16'h1);
        chk("rr_dt_data", 0, dt_data[0], 16'hBEEF);
        chk("rr_fetch_waiting", 0, 16'(if_ready[0]), 16'h0);
        dt_req[0] = 1'b0;
        tick(53);
        chk("rr_fetch_not_ready", 0, 16'(if_ready[0]), 16'h0);
        tick(1);
        chk("rr_fetch_ready", 0, 16'(if_ready[0]), 16'h1);
        chk("rr_fetch_data", 0, if_data[0], mem[9'h010]);
        tick(1);

        // Busy blocks the grant; busy and dt_req drop mid-transaction are ignored
        busy[0]    = 1'b1;
        dt_req[0]  = 1'b1;
        dt_addr[0] = 9'h0C3;
        snap_tog   = pin_tog0;
        tick(20);
        chk("busy_no_toggle", 0, 16'(pin_tog0 - snap_tog), 16'd0);
        chk("busy_no_grant", 0, 16'(arshft[0]), 16'h0);
        busy[0] = 1'b0;
        tick(1);
        chk("busy_grant", 0, 16'(arshft[0]), 16'h1);
        tick(10);
        dt_req[0] = 1'b0;
        busy[0]   = 1'b1;
        tick(41);
        chk("busy_ack_early", 0, 16'(dt_ack[0]), 16'h0);
        tick(1);
        chk("busy_ack", 0, 16'(dt_ack[0]), 16'h1);
        chk("busy_dt_data", 0, dt_data[0], mem[9'h0C3]);
        busy[0] = 1'b0;
        tick(2);

        // Reset during SHIFT abandons the read; the reissued read completes
        dt_req[0]  = 1'b1;
        dt_addr[0] = 9'h0F0;
        tick(30);
        chk("shift_active", 0, 16'(drshft[0]), 16'h1);
        snap_ack = ack_cnt0;
        reset_n  = 1'b0;
        #1 chk_idle_pins(0);
        tick(2);
        reset_n = 1'b1;
        tick(52);
        chk("rst_no_ack", 0, 16'(ack_cnt0 - snap_ack), 16'd0);
        tick(1);
        chk("reissue_ack", 0, 16'(dt_ack[0]), 16'h1);
        chk("reissue_dt_data", 0, dt_data[0], mem[9'h0F0]);
        dt_req[0] = 1'b0;
        tick(54);
        chk("reissue_fetch_ready", 0, 16'(if_ready[0]), 16'h1);
        chk("reissue_fetch_data", 0, if_data[0], mem[9'h010]);
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
